// File: rtl/somador_cla_pipeline_if.sv
// somador_cla_pipeline_if: operand/result handshake bundle for the pipelined CLA adder
interface somador_cla_pipeline_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, Cin, Sub, out_valid, out_ready, V, Z;
  logic [WIDTH-1:0] A, B;
  logic [WIDTH:0] S;
  modport master(output in_valid, A, B, Cin, Sub, out_ready, input in_ready, out_valid, S, V, Z);
  modport slave(input in_valid, A, B, Cin, Sub, out_ready, output in_ready, out_valid, S, V, Z);
endinterface

// File: rtl/somador_cla_pipeline.sv
// somador_cla_pipeline: pipelined WIDTH-bit carry-lookahead adder/subtractor, one BLOCK-bit group per stage
module somador_cla_pipeline #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input logic clk,
  input logic rst_n,
  somador_cla_pipeline_if.slave bus
);
  localparam int NSTG = WIDTH / BLOCK;
  logic [WIDTH-1:0] a_r [NSTG];
  logic [WIDTH-1:0] b_r [NSTG];
  logic [WIDTH-1:0] sum_r [NSTG];
  logic c_r [NSTG];
  logic vld_r [NSTG];
  logic v_r, z_r, adv;
  // every carry is a flat sum of products of g, p and the group carry-in
  function automatic logic [BLOCK:0] cla(input logic [BLOCK-1:0] a, input logic [BLOCK-1:0] b, input logic ci);
    logic [BLOCK-1:0] g, p;
    logic [BLOCK:0] c;
    logic t;
    g = a & b;
    p = a ^ b;
    c = '0;
    for (int i = 0; i <= BLOCK; i++) begin
      t = ci;
      for (int j = 0; j < i; j++) t = t & p[j];
      c[i] = t;
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int m = j + 1; m < i; m++) t = t & p[m];
        c[i] = c[i] | t;
      end
    end
    return {c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction
  assign adv = !vld_r[NSTG-1] || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = vld_r[NSTG-1];
  assign bus.S = {c_r[NSTG-1], sum_r[NSTG-1]};
  assign bus.V = v_r;
  assign bus.Z = z_r;
  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [WIDTH-1:0] ai, bi, si, sn;
    logic ci, vi;
    logic [BLOCK:0] grp;
    if (k == 0) begin : g_in
      assign ai = bus.A;
      assign bi = bus.Sub ? ~bus.B : bus.B;
      assign ci = bus.Cin ^ bus.Sub;
      assign si = '0;
      assign vi = bus.in_valid;
    end else begin : g_mid
      assign ai = a_r[k-1];
      assign bi = b_r[k-1];
      assign ci = c_r[k-1];
      assign si = sum_r[k-1];
      assign vi = vld_r[k-1];
    end
    assign grp = cla(ai[k*BLOCK +: BLOCK], bi[k*BLOCK +: BLOCK], ci);
    always_comb begin
      sn = si;
      sn[k*BLOCK +: BLOCK] = grp[BLOCK-1:0];
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        vld_r[k] <= 1'b0;
        c_r[k] <= 1'b0;
        sum_r[k] <= '0;
        a_r[k] <= '0;
        b_r[k] <= '0;
      end else if (adv) begin
        vld_r[k] <= vi;
        c_r[k] <= grp[BLOCK];
        sum_r[k] <= sn;
        a_r[k] <= ai;
        b_r[k] <= bi;
      end
    if (k == NSTG - 1) begin : g_flags
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          v_r <= 1'b0;
          z_r <= 1'b0;
        end else if (adv) begin
          v_r <= (ai[WIDTH-1] == bi[WIDTH-1]) && (sn[WIDTH-1] != ai[WIDTH-1]);
          z_r <= sn == '0;
        end
    end
  end
endmodule

// File: tb/tb_somador_cla_pipeline.sv
// tb_somador_cla_pipeline: scoreboard-checked bench for the 16-bit, 4-stage CLA pipeline
module tb_somador_cla_pipeline;
  logic clk, rst_n;
  int errors = 0;
  int checks = 0;
  logic [18:0] sb [$];
  somador_cla_pipeline_if #(.WIDTH(16)) bus();
  somador_cla_pipeline #(.WIDTH(16), .BLOCK(4)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    logic [15:0] bx;
    logic [16:0] s;
    bx = sub ? ~b : b;
    s = {1'b0, a} + {1'b0, bx} + {16'b0, cin ^ sub};
    return {s, (a[15] == bx[15]) && (s[15] != a[15]), s[15:0] == 16'h0};
  endfunction
  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else begin
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_beat got S=%h V=%b Z=%b", bus.S, bus.V, bus.Z);
        end else begin
          logic [18:0] e;
          e = sb.pop_front();
          if ({bus.S, bus.V, bus.Z} !== e) begin
            errors++;
            $display("FAIL sb_result got S=%h V=%b Z=%b exp S=%h V=%b Z=%b", bus.S, bus.V, bus.Z, e[18:2], e[1], e[0]);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.A, bus.B, bus.Cin, bus.Sub));
    end
  end
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    int n;
    logic acc;
    bus.A = a;
    bus.B = b;
    bus.Cin = cin;
    bus.Sub = sub;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=0 for %0d cycles exp accept", n);
    end
  endtask
  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.A = '0;
    bus.B = '0;
    bus.Cin = 1'b0;
    bus.Sub = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
    checks++; if ({bus.S, bus.V, bus.Z} !== 19'h0) begin errors++; $display("FAIL rst_svz got %h exp 0", {bus.S, bus.V, bus.Z}); end
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask
  task automatic test_basic;
    int n;
    send(16'h0002, 16'h0008, 1'b0, 1'b0);
    wait_out(n);
    checks++; if (n + 1 !== 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", n + 1); end
    checks++; if (bus.S !== 17'h0000A) begin errors++; $display("FAIL basic_S got %h exp 0000a", bus.S); end
    checks++; if ({bus.V, bus.Z} !== 2'b00) begin errors++; $display("FAIL basic_VZ got %b exp 00", {bus.V, bus.Z}); end
    idle(6);
  endtask
  task automatic test_back_to_back;
    logic [16:0] gs [3];
    int gc [3];
    int cnt;
    cnt = 0;
    send(16'h0006, 16'h000A, 1'b0, 1'b0);
    send(16'h000A, 16'h0006, 1'b1, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid) begin
        if (cnt < 3) begin
          gs[cnt] = bus.S;
          gc[cnt] = c;
        end
        cnt++;
      end
      @(posedge clk);
      #1;
    end
    checks++; if (cnt !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", cnt); end
    if (cnt >= 3) begin
      checks++; if (gs[0] !== 17'h00010) begin errors++; $display("FAIL b2b_S0 got %h exp 00010", gs[0]); end
      checks++; if (gs[1] !== 17'h00011) begin errors++; $display("FAIL b2b_S1 got %h exp 00011", gs[1]); end
      checks++; if (gs[2] !== 17'h1FFFF) begin errors++; $display("FAIL b2b_S2 got %h exp 1ffff", gs[2]); end
      checks++; if (gc[2] - gc[0] !== 2) begin errors++; $display("FAIL b2b_consecutive got span %0d exp 2", gc[2] - gc[0]); end
    end
    idle(4);
  endtask
  task automatic test_overflow_zero;
    int n;
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_out(n);
    checks++; if ({bus.S, bus.V, bus.Z} !== {17'h08000, 2'b10}) begin errors++; $display("FAIL ovf_add got S=%h V=%b Z=%b exp S=08000 V=1 Z=0", bus.S, bus.V, bus.Z); end
    idle(2);
    send(16'h1234, 16'h1234, 1'b0, 1'b1);
    wait_out(n);
    checks++; if ({bus.S, bus.V, bus.Z} !== {17'h10000, 2'b01}) begin errors++; $display("FAIL zero_sub got S=%h V=%b Z=%b exp S=10000 V=0 Z=1", bus.S, bus.V, bus.Z); end
    idle(6);
  endtask
  task automatic test_borrow_carry;
    int n;
    send(16'h0000, 16'h0001, 1'b0, 1'b1);
    wait_out(n);
    checks++; if ({bus.S, bus.V, bus.Z} !== {17'h0FFFF, 2'b00}) begin errors++; $display("FAIL borrow got S=%h V=%b Z=%b exp S=0ffff V=0 Z=0", bus.S, bus.V, bus.Z); end
    idle(2);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_out(n);
    checks++; if ({bus.S, bus.V, bus.Z} !== {17'h10000, 2'b01}) begin errors++; $display("FAIL carry_chain got S=%h V=%b Z=%b exp S=10000 V=0 Z=1", bus.S, bus.V, bus.Z); end
    idle(2);
    send(16'h5555, 16'h5556, 1'b1, 1'b1);
    wait_out(n);
    checks++; if ({bus.S, bus.V, bus.Z} !== {17'h0FFFE, 2'b00}) begin errors++; $display("FAIL sub_borrow_in got S=%h V=%b Z=%b exp S=0fffe V=0 Z=0", bus.S, bus.V, bus.Z); end
    idle(6);
  endtask
  task automatic test_backpressure;
    logic [15:0] ba [6] = '{16'h1111, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h8000, 16'h00F0};
    logic [15:0] bb [6] = '{16'h2222, 16'h0001, 16'h0001, 16'h0001, 16'h8000, 16'h0F10};
    logic [5:0] bs = 6'b101010;
    logic [18:0] ex [6];
    logic [16:0] held;
    int n, got;
    for (int i = 0; i < 6; i++) ex[i] = model(ba[i], bb[i], 1'b0, bs[i]);
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(ba[i], bb[i], 1'b0, bs[i]);
      end
    join_none
    wait_out(n);
    held = bus.S;
    checks++; if (held !== ex[0][18:2]) begin errors++; $display("FAIL bp_head got %h exp %h", held, ex[0][18:2]); end
    repeat (5) begin
      @(posedge clk);
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b exp 1", bus.out_valid); end
      checks++; if (bus.S !== held) begin errors++; $display("FAIL bp_S_stable got %h exp %h", bus.S, held); end
    end
    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      if (bus.out_valid) begin
        checks++; if ({bus.S, bus.V, bus.Z} !== ex[got]) begin errors++; $display("FAIL bp_order[%0d] got %h exp %h", got, {bus.S, bus.V, bus.Z}, ex[got]); end
        got++;
      end
      @(posedge clk);
      #1;
    end
    checks++; if (got !== 6) begin errors++; $display("FAIL bp_count got %0d exp 6", got); end
    idle(4);
  endtask
  task automatic test_reset_midflight;
    int n, seen;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h0F0F, 16'h0101, 1'b1, 1'b0);
    send(16'h4000, 16'h0001, 1'b0, 1'b1);
    idle(1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b exp 1", bus.in_ready); end
    checks++; if ({bus.S, bus.V, bus.Z} !== 19'h0) begin errors++; $display("FAIL mid_svz got %h exp 0", {bus.S, bus.V, bus.Z}); end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      if (bus.out_valid) seen++;
      @(posedge clk);
      #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_stale got %0d beats exp 0", seen); end
    send(16'h8000, 16'h8000, 1'b0, 1'b0);
    wait_out(n);
    checks++; if (n + 1 !== 4) begin errors++; $display("FAIL mid_latency got %0d exp 4", n + 1); end
    checks++; if ({bus.S, bus.V, bus.Z} !== {17'h10000, 2'b11}) begin errors++; $display("FAIL mid_result got S=%h V=%b Z=%b exp S=10000 V=1 Z=1", bus.S, bus.V, bus.Z); end
    idle(6);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow_zero();
    test_borrow_carry();
    test_backpressure();
    test_reset_midflight();
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL sb_drain got %0d pending exp 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
